// File: rtl/modulo_controlador_conversion_bcd_pkg.sv
// rtl/modulo_controlador_conversion_bcd_pkg.sv - shared FSM state type and BCD digit constants
package paqueteConversionBCD;

  // Controller states: idle, one shift/correct iteration per clock, completion strobe
  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    DESPLAZAR = 2'd1,
    FIN       = 2'd2
  } estado_t;

  // Width of one BCD digit
  localparam int ANCHO_DIGITO = 4;
  // Digits at or above this value would overflow past 9 after doubling
  localparam int UMBRAL_CORRECCION = 5;
  // Amount added so the doubled digit carries into the next decade
  localparam int VALOR_CORRECCION = 3;

endpackage

// File: rtl/modulo_controlador_conversion_bcd_correccion.sv
// rtl/modulo_controlador_conversion_bcd_correccion.sv - per-digit add-3 correction ahead of a shift
module modulo_correccion_digito
  import paqueteConversionBCD::*;
(
  input  logic [ANCHO_DIGITO-1:0] digito_i,
  output logic [ANCHO_DIGITO-1:0] digito_o
);

  localparam logic [ANCHO_DIGITO-1:0] UMBRAL = ANCHO_DIGITO'(UMBRAL_CORRECCION);
  localparam logic [ANCHO_DIGITO-1:0] VALOR  = ANCHO_DIGITO'(VALOR_CORRECCION);

  // Add 3 when the digit would exceed 9 once shifted left
  always_comb begin
    digito_o = digito_i;
    if (digito_i >= UMBRAL) begin
      digito_o = digito_i + VALOR;
    end
  end

endmodule

// File: rtl/modulo_controlador_conversion_bcd.sv
// rtl/modulo_controlador_conversion_bcd.sv - iterative double-dabble binary to BCD converter
module modulo_controlador_conversion_bcd
  import paqueteConversionBCD::*;
#(
  parameter int ANCHO   = 8,
  parameter int DIGITOS = 3
) (
  input  logic                 reloj,
  input  logic                 reinicio,
  input  logic                 inicio,
  input  logic [ANCHO-1:0]     entradaBinario,
  output logic                 ocupado,
  output logic                 listo,
  output logic [4*DIGITOS-1:0] salidaBCD
);

  // Caller must choose DIGITOS so that 10^DIGITOS > 2^ANCHO-1 (8/3 and 4/2 are the intended pairs)
  localparam int ANCHO_CNT = $clog2(ANCHO + 1);
  localparam int ANCHO_BCD = ANCHO_DIGITO * DIGITOS;
  localparam logic [ANCHO_CNT-1:0] CNT_FINAL = ANCHO_CNT'(ANCHO);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO   = ANCHO_CNT'(1);

  estado_t              estado_q, estado_d;
  logic [ANCHO-1:0]     desp_q, desp_d;
  logic [ANCHO_BCD-1:0] bcd_q, bcd_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
  logic [ANCHO_BCD-1:0] salida_q, salida_d;
  logic                 listo_q, listo_d;
  logic                 ocupado_q, ocupado_d;

  logic [ANCHO_BCD-1:0] corregido;
  logic [ANCHO_BCD-1:0] bcd_sig;
  logic [ANCHO-1:0]     desp_sig;

  // One correction cell per scratch digit, all evaluated in parallel each iteration
  for (genvar i = 0; i < DIGITOS; i++) begin : g_correccion
    modulo_correccion_digito u_correccion (
      .digito_i (bcd_q[i*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .digito_o (corregido[i*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  // Corrected scratch and operand shift left together as one long register
  always_comb begin
    {bcd_sig, desp_sig} = {corregido, desp_q} << 1;
  end

  // Next-state and datapath control; the result register only updates on the final shift
  always_comb begin
    estado_d = estado_q;
    desp_d   = desp_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    salida_d = salida_q;
    listo_d  = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (inicio) begin
          desp_d   = entradaBinario;
          bcd_d    = '0;
          cnt_d    = '0;
          estado_d = DESPLAZAR;
        end
      end
      DESPLAZAR: begin
        bcd_d  = bcd_sig;
        desp_d = desp_sig;
        cnt_d  = cnt_q + CNT_UNO;
        if (cnt_d == CNT_FINAL) begin
          estado_d = FIN;
          salida_d = bcd_sig;
          listo_d  = 1'b1;
        end
      end
      FIN: begin
        estado_d = ESPERA;
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
    ocupado_d = (estado_d != ESPERA);
  end

  // State and output registers; reset aborts any conversion without a completion strobe
  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      estado_q  <= ESPERA;
      desp_q    <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      salida_q  <= '0;
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      desp_q    <= desp_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      salida_q  <= salida_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign salidaBCD = salida_q;

endmodule

// File: doc/modulo_controlador_conversion_bcd.md
MODULO_CONTROLADOR_CONVERSION_BCD -- requirements
Module: modulo_controlador_conversion_bcd

Interface
REQ-001 Parameter ANCHO, default 8, width of the binary operand in bits.
REQ-002 Parameter DIGITOS, default 3, number of BCD digits produced; the block SHALL support only combinations where 10^DIGITOS > 2^ANCHO-1 (8/3 required, 4/2 also legal).
REQ-003 reloj  input  1  single system clock, all state updates on rising edge.
REQ-004 reinicio  input  1  reset, synchronous, active-low.
REQ-005 inicio  input  1  start request; sampled only while ocupado is low.
REQ-006 entradaBinario  input  ANCHO  unsigned operand, sampled in the same cycle as an accepted inicio.
REQ-007 ocupado  output  1  high from the cycle after acceptance until the cycle after listo.
REQ-008 listo  output  1  one-cycle completion strobe.
REQ-009 salidaBCD  output  4*DIGITOS  packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-010 Conversion SHALL use iterative shift-and-add-3 (double dabble): one iteration per clock, ANCHO iterations per operand.
REQ-011 FSM states SHALL be ESPERA, DESPLAZAR, FIN; no other reachable states.
REQ-012 ESPERA: on edge k with inicio=1, load entradaBinario into a shift register, clear BCD scratch and iteration counter, go to DESPLAZAR; otherwise remain.
REQ-013 DESPLAZAR: each edge, every scratch digit >= 5 SHALL get +3, then {scratch, shift register} shifts left by one; counter increments.
REQ-014 After the ANCHO-th shift (edge k+ANCHO) the FSM SHALL enter FIN and load salidaBCD from the scratch in the same edge.
REQ-015 FIN: listo=1 for exactly that cycle; next edge returns to ESPERA unconditionally.
REQ-016 Latency: with inicio accepted at edge k, listo SHALL be high in the cycle between edges k+ANCHO and k+ANCHO+1 (cycle 9 after acceptance for ANCHO=8).
REQ-017 ocupado SHALL be high in DESPLAZAR and FIN, low in ESPERA (Moore, no combinational path from inicio).
REQ-018 inicio asserted while ocupado is high (including the FIN cycle) SHALL be ignored, not queued; entradaBinario changes during conversion SHALL not affect the result.
REQ-019 Earliest back-to-back accept: inicio high in the first ESPERA cycle after FIN, i.e. edge k+ANCHO+1.
REQ-020 salidaBCD SHALL hold its last value between conversions and never show intermediate scratch values.
REQ-021 Every output digit SHALL be in 0..9; for ANCHO=8 the hundreds digit SHALL be in 0..2.
REQ-022 Counter width SHALL be $clog2(ANCHO+1); terminal compare is against ANCHO, no wrap.

Reset
REQ-023 With reinicio=0 at an edge: state=ESPERA, ocupado=0, listo=0, salidaBCD=0, scratch/shift register/counter=0.
REQ-024 Reset SHALL override inicio in the same edge and abort any conversion in progress without asserting listo.

Structure
REQ-025 Shared package paqueteConversionBCD SHALL hold the FSM state enum and the digit constants (ancho de digito = 4, umbral de correccion = 5, valor de correccion = 3).
REQ-026 One sub-module modulo_correccion_digito (4-bit combinational: add 3 if >= 5) SHALL be instantiated DIGITOS times via generate.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Reset, then entradaBinario=8'd0, inicio pulse -> listo at cycle 9, salidaBCD=12'h000, ocupado high cycles 1-9.
REQ-029 Sweep 0..255, one conversion each -> salidaBCD equals decimal digits (e.g. 8'd255 -> 12'h255, 8'd99 -> 12'h099, 8'd100 -> 12'h100).
REQ-030 entradaBinario=8'd37 accepted, then inicio=1 and entradaBinario=8'd200 held through FIN -> single listo, salidaBCD=12'h037, next accept only at cycle 10.
REQ-031 Back-to-back: 8'd15 then 8'd128 with inicio high in cycle 10 -> listo at cycles 9 and 19, results 12'h015 then 12'h128.
REQ-032 reinicio=0 at cycle 4 of a conversion of 8'd250 -> no listo, ocupado=0, salidaBCD=12'h000; new conversion of 8'd7 -> 12'h007 in 9 cycles.
REQ-033 ANCHO=4, DIGITOS=2 instance, inputs 0..15 -> salidaBCD 8'h00..8'h15, listo at cycle 5.
